// File: rtl/regex_mem_arbiter.sv
// regex_mem_arbiter
// -----------------------------------------------------------------------------
// Purpose: lets N_REQ pipelined regex CPUs share one synchronous instruction
// RAM. A round-robin arbiter picks one requester at a time. The fetch runs
// through IDLE -> FETCH -> WAIT -> RESP, and only one fetch is in flight.
// The winner then gets a one-cycle req_ready strobe together with the word.
//
// Optional feature (macro REGEX_MEM_ARB_CACHE_EN): a single-entry read cache
// holding the last fetched address and its data. A grant that hits the cache
// skips the RAM and goes straight to RESP. The invalidate input clears the
// cache. Without the macro, no cache storage exists and invalidate is ignored.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   req_valid  - per-requester fetch request
//   req_addr   - per-requester fetch address, slice i = requester i
//   req_ready  - per-requester one-cycle data-return strobe
//   rsp_data   - returned instruction word, valid while a req_ready bit is high
//   mem_en     - RAM read enable (one cycle per fetch)
//   mem_addr   - RAM read address (holds its last value between fetches)
//   mem_rdata  - RAM read data, valid the cycle after mem_en
//   invalidate - program memory was rewritten
//   busy       - high whenever the FSM is not in IDLE
//   grant_id   - index of the requester being served
// -----------------------------------------------------------------------------
module regex_mem_arbiter #(
    parameter int N_REQ             = 4,
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int ID_BITS           = $clog2(N_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ*MEMORY_ADDR_WIDTH-1:0]   req_addr,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [MEMORY_WIDTH-1:0]              rsp_data,
    output logic                                 mem_en,
    output logic [MEMORY_ADDR_WIDTH-1:0]         mem_addr,
    input  logic [MEMORY_WIDTH-1:0]              mem_rdata,
    input  logic                                 invalidate,
    output logic                                 busy,
    output logic [ID_BITS-1:0]                   grant_id
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, RESP} state_e;

    localparam logic [N_REQ-1:0] REQ_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    state_e                         state_q, state_d;
    logic [N_REQ-1:0]               req_ready_q, req_ready_d;
    logic                           mem_en_q, mem_en_d;
    logic [MEMORY_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [MEMORY_WIDTH-1:0]        rsp_q, rsp_d;
    logic                           busy_q, busy_d;
    logic [ID_BITS-1:0]             grant_id_q, grant_id_d;
    logic [ID_BITS-1:0]             last_grant_q, last_grant_d;

    logic                           win_found;
    logic [ID_BITS-1:0]             win_id;
    logic [ID_BITS-1:0]             rr_idx;
    logic [MEMORY_ADDR_WIDTH-1:0]   win_addr;
    logic                           cache_hit;
    logic [MEMORY_WIDTH-1:0]        cache_data;

    // Round-robin search starting just after the last winner. The modulo
    // keeps the wrap correct for N_REQ values that are not a power of two.
    always_comb begin
        win_found = 1'b0;
        win_id    = last_grant_q;
        rr_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = ID_BITS'((int'(last_grant_q) + k) % N_REQ);
            if (!win_found && req_valid[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
        win_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_BITS'(i) == win_id) begin
                win_addr = req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

`ifdef REGEX_MEM_ARB_CACHE_EN
    logic                           cache_valid_q, cache_valid_d;
    logic [MEMORY_ADDR_WIDTH-1:0]   cache_tag_q, cache_tag_d;
    logic [MEMORY_WIDTH-1:0]        cache_data_q, cache_data_d;

    // Every RAM capture refills the entry. Invalidate wins over a refill in
    // the same cycle, so the entry cannot hold data fetched from stale memory.
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_tag_d   = cache_tag_q;
        cache_data_d  = cache_data_q;
        if (state_q == WAIT) begin
            cache_valid_d = 1'b1;
            cache_tag_d   = mem_addr_q;
            cache_data_d  = mem_rdata;
        end
        if (invalidate) begin
            cache_valid_d = 1'b0;
        end
    end

    // An invalidate arriving in the same cycle as the hit decision forces a miss.
    assign cache_hit  = cache_valid_q && !invalidate && (cache_tag_q == win_addr);
    assign cache_data = cache_data_q;
`else
    logic unused_invalidate;

    assign unused_invalidate = invalidate;
    assign cache_hit         = 1'b0;
    assign cache_data        = '0;
`endif

    // Next-state and registered-output logic. Outputs are computed one cycle
    // ahead, so mem_en and req_ready come straight from flops.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = '0;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        rsp_d        = rsp_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    if (cache_hit) begin
                        rsp_d       = cache_data;
                        req_ready_d = REQ_ONE << win_id;
                        state_d     = RESP;
                    end else begin
                        mem_addr_d = win_addr;
                        mem_en_d   = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                rsp_d       = mem_rdata;
                req_ready_d = REQ_ONE << grant_id_q;
                state_d     = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reset drops any in-flight fetch. last_grant starts at N_REQ-1 so that
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_ready_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_addr_q    <= '0;
            rsp_q         <= '0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            last_grant_q  <= ID_BITS'(N_REQ - 1);
`ifdef REGEX_MEM_ARB_CACHE_EN
            cache_valid_q <= 1'b0;
            cache_tag_q   <= '0;
            cache_data_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            mem_en_q      <= mem_en_d;
            mem_addr_q    <= mem_addr_d;
            rsp_q         <= rsp_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            last_grant_q  <= last_grant_d;
`ifdef REGEX_MEM_ARB_CACHE_EN
            cache_valid_q <= cache_valid_d;
            cache_tag_q   <= cache_tag_d;
            cache_data_q  <= cache_data_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_data  = rsp_q;
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_regex_mem_arbiter.sv
// tb_regex_mem_arbiter
// -----------------------------------------------------------------------------
// Directed bench for regex_mem_arbiter. The stimulus pushes the expected strobe
// (vector, data, grant id, latency) into a scoreboard queue. A negedge monitor
// pops one entry for every req_ready strobe. The RAM model returns
// 0x14100 + address, one cycle after mem_en.
// -----------------------------------------------------------------------------
module tb_regex_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int DW = 20;
    localparam int IB = 2;
    localparam logic [N-1:0] ONE_HOT0 = 4'b0001;

`ifdef REGEX_MEM_ARB_CACHE_EN
    localparam bit CACHE_BUILD = 1'b1;
`else
    localparam bit CACHE_BUILD = 1'b0;
`endif

    typedef struct {
        logic [N-1:0]  ready;
        logic [DW-1:0] data;
        int            id;
        int            issue;
        int            lat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   rsp_data;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata = '0;
    logic            invalidate = 1'b0;
    logic            busy;
    logic [IB-1:0]   grant_id;

    exp_t          sb[$];
    exp_t          mon_e;
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            rsp_seen = 0;
    int            mem_en_cnt = 0;
    logic [AW-1:0] last_fetch_addr = '0;
    logic          prev_mem_en = 1'b0;

    regex_mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_data   (rsp_data),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .invalidate (invalidate),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM model with a fixed, easy-to-predict content.
    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return 20'h14100 + {9'b0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= ram_word(mem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: counts RAM reads, checks the mem_en pulse width and pops the
    // scoreboard on every strobe.
    always @(negedge clk) begin
        if (mem_en) begin
            mem_en_cnt++;
            last_fetch_addr = mem_addr;
            checkOutput("mem_en_width", 32'(prev_mem_en), 32'd0);
        end
        prev_mem_en = mem_en;
        if (req_ready != '0) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", 32'(req_ready), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("req_ready", 32'(req_ready), 32'(mon_e.ready));
                checkOutput("rsp_data", 32'(rsp_data), 32'(mon_e.data));
                checkOutput("grant_id", 32'(grant_id), 32'(mon_e.id));
                if (mon_e.lat > 0) begin
                    checkOutput("latency", 32'(cyc - mon_e.issue + 1), 32'(mon_e.lat));
                end
            end
        end
    end

    task automatic waitResponses(input int target);
        int guard = 0;
        while (rsp_seen < target && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (rsp_seen < target) begin
            checkOutput("response_timeout", 32'(rsp_seen), 32'(target));
        end
    endtask

    task automatic pushExpect(input int id, input logic [DW-1:0] data, input int lat);
        exp_t e;
        e.ready = ONE_HOT0 << id;
        e.data  = data;
        e.id    = id;
        e.issue = cyc + 1;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    // Single-requester transaction issued from IDLE; returns once the DUT is
    // back in IDLE with the request withdrawn.
    task automatic applyStimulus(input int id, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input int lat,
                                 input bit fetch);
        int en_before;
        int seen_before;
        en_before   = mem_en_cnt;
        seen_before = rsp_seen;
        req_addr[id*AW +: AW] = addr;
        req_valid[id] = 1'b1;
        pushExpect(id, data, lat);
        waitResponses(seen_before + 1);
        req_valid[id] = 1'b0;
        checkOutput("fetch_count", 32'(mem_en_cnt - en_before), fetch ? 32'd1 : 32'd0);
        if (fetch) checkOutput("fetch_addr", 32'(last_fetch_addr), 32'(addr));
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen0;
        int en0;
        #3 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single request, miss path, 3-cycle latency.
        applyStimulus(0, 11'h0AA, 20'h141AA, 3, 1'b1);

        // Four continuous requesters: order 0,1,2,3,0 after reset.
        doReset();
        req_addr = {11'h040, 11'h030, 11'h020, 11'h010};
        seen0 = rsp_seen;
        en0   = mem_en_cnt;
        pushExpect(0, 20'h14110, 0);
        pushExpect(1, 20'h14120, 0);
        pushExpect(2, 20'h14130, 0);
        pushExpect(3, 20'h14140, 0);
        pushExpect(0, 20'h14110, 0);
        req_valid = 4'b1111;
        waitResponses(seen0 + 5);
        req_valid = 4'b0000;
        @(negedge clk);
        checkOutput("rr_fetch_count", 32'(mem_en_cnt - en0), 32'd5);

        // Requester 2 withdraws during FETCH; it is still served, then 3.
        doReset();
        req_addr = {11'h077, 11'h123, 11'h000, 11'h000};
        seen0 = rsp_seen;
        pushExpect(2, 20'h14223, 3);
        pushExpect(3, 20'h14177, 0);
        req_valid = 4'b1100;
        @(negedge clk);
        checkOutput("fetch_mem_en", 32'(mem_en), 32'd1);
        checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h123);
        checkOutput("fetch_busy", 32'(busy), 32'd1);
        checkOutput("fetch_grant_id", 32'(grant_id), 32'd2);
        req_valid = 4'b1000;
        waitResponses(seen0 + 2);
        req_valid = 4'b0000;
        @(negedge clk);

        // Reset during WAIT drops the fetch; requester 2 is served afterwards.
        doReset();
        req_addr = {11'h000, 11'h2C0, 11'h000, 11'h055};
        req_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wait_busy", 32'(busy), 32'd1);
        checkOutput("wait_mem_en", 32'(mem_en), 32'd0);
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd0);
        checkOutput("abort_grant_id", 32'(grant_id), 32'd0);
        req_valid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        seen0 = rsp_seen;
        rst = 1'b1;
        pushExpect(2, 20'h143C0, 3);
        waitResponses(seen0 + 1);
        req_valid = 4'b0000;
        @(negedge clk);

        // Repeated address: hit in the cache build, full fetch otherwise;
        // an invalidate between fetches always forces a RAM read.
        applyStimulus(1, 11'h13A, 20'h1423A, 3, 1'b1);
        applyStimulus(1, 11'h13A, 20'h1423A, CACHE_BUILD ? 1 : 3, !CACHE_BUILD);
        invalidate = 1'b1;
        @(negedge clk);
        invalidate = 1'b0;
        @(negedge clk);
        applyStimulus(1, 11'h13A, 20'h1423A, 3, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regex_mem_arbiter.md
REGEX_MEM_ARBITER -- requirements
Module: regex_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of regex_cpu_pipelined instances sharing one instruction memory; legal range 2..16.
REQ-002 Parameter MEMORY_WIDTH, default 20: instruction word width.
REQ-003 Parameter MEMORY_ADDR_WIDTH, default 11: instruction address width.
REQ-004 Parameter ID_BITS, default $clog2(N_REQ): requester index width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  N_REQ  per-CPU fetch request; connects to each CPU's memory_valid.
REQ-008 req_addr  input  N_REQ*MEMORY_ADDR_WIDTH  per-CPU fetch address; slice i belongs to requester i.
REQ-009 req_ready  output  N_REQ  per-CPU one-cycle data-return strobe; connects to each CPU's memory_ready.
REQ-010 rsp_data  output  MEMORY_WIDTH  returned instruction word, shared by all requesters; meaningful only while a req_ready bit is high.
REQ-011 mem_en  output  1  read enable to the synchronous instruction RAM.
REQ-012 mem_addr  output  MEMORY_ADDR_WIDTH  RAM read address.
REQ-013 mem_rdata  input  MEMORY_WIDTH  RAM read data, valid exactly one cycle after mem_en.
REQ-014 invalidate  input  1  program-memory-rewritten notification.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 grant_id  output  ID_BITS  index of the requester currently being served; holds its last value while in IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, FETCH, WAIT and RESP.
REQ-018 In IDLE with any req_valid bit high, the block SHALL select a winner round-robin, searching upward from last_grant+1 modulo N_REQ.
REQ-019 On selection, the block SHALL register the winner into grant_id and last_grant, register its address, and enter FETCH.
REQ-020 In FETCH the block SHALL assert mem_en=1 with mem_addr equal to the registered address for exactly one cycle, then enter WAIT.
REQ-021 In WAIT the block SHALL capture mem_rdata into the response register and enter RESP.
REQ-022 In RESP the block SHALL assert req_ready[grant_id]=1 for exactly one cycle, drive rsp_data from the response register, and return to IDLE.
REQ-023 Request-to-strobe latency on a miss SHALL be 3 cycles: request sampled at edge N, req_ready high in cycle N+3.
REQ-024 The next arbitration SHALL occur no earlier than the IDLE cycle after RESP.
REQ-025 At most one req_ready bit SHALL be high in any cycle.
REQ-026 At most one transaction SHALL be outstanding at any time.
REQ-027 Deassertion of the granted req_valid mid-transaction SHALL NOT abort the transaction; the req_ready strobe is still issued.
REQ-028 A requester whose req_valid is high continuously SHALL be granted within N_REQ arbitrations (no starvation).
REQ-029 Outside FETCH, mem_en SHALL be 0 and mem_addr SHALL hold its last value.
REQ-030 Outside RESP, req_ready SHALL be all zero.
REQ-031 invalidate SHALL have no effect when REGEX_MEM_ARB_CACHE_EN is undefined.

Reset
REQ-032 Assertion of rst SHALL immediately force: state=IDLE, req_ready=0, mem_en=0, busy=0, mem_addr=0, rsp_data=0, grant_id=0, last_grant=N_REQ-1 (requester 0 wins first).
REQ-033 Reset asserted mid-transaction SHALL drop the transaction with no req_ready strobe; the requester is re-served after release if it still requests.
REQ-034 Outputs SHALL leave their reset values no earlier than the first rising edge after rst deasserts.

Configuration
REQ-035 With macro REGEX_MEM_ARB_CACHE_EN defined, the block SHALL hold a single-entry cache: last fetched address, its data word and a valid bit.
REQ-036 (Cache enabled) On an IDLE grant whose address equals the cached address while the valid bit is set, the block SHALL load the response register from the cache and enter RESP directly: 1-cycle latency, mem_en stays 0.
REQ-037 (Cache enabled) Every WAIT capture SHALL refill the cache entry and set its valid bit.
REQ-038 (Cache enabled) invalidate=1 SHALL clear the valid bit.
REQ-039 (Cache enabled) invalidate=1 coinciding with a hit decision SHALL force a miss.
REQ-040 (Cache enabled) invalidate=1 coinciding with a WAIT refill SHALL leave the valid bit clear.
REQ-041 (Cache enabled) Reset SHALL clear the valid bit.
REQ-042 Without REGEX_MEM_ARB_CACHE_EN, no cache storage SHALL exist and every grant SHALL follow IDLE->FETCH->WAIT->RESP.

Verification
REQ-043 Single request: req_valid=4'b0001, addr0=0x0AA, RAM[0x0AA]=0x1_41AA -> mem_en=1 with mem_addr=0x0AA once; req_ready=4'b0001 with rsp_data=0x1_41AA exactly 3 cycles after the request.
REQ-044 All four requesting continuously with distinct addresses -> grant order 0,1,2,3,0; each req_ready one cycle wide; never two bits high.
REQ-045 Requester 2 drops req_valid in the FETCH cycle -> req_ready[2] still pulses; the following grant goes to requester 3.
REQ-046 rst asserted in WAIT -> no req_ready strobe, busy=0 immediately; after release with req_valid=4'b0100 held, requester 0 is not served and requester 2 is granted.
REQ-047 Cache build: two consecutive fetches of 0x13A -> second strobe 1 cycle after request with mem_en=0; with invalidate pulsed between them -> second fetch takes 3 cycles.
REQ-048 Cache-less build: repeated address 0x13A -> every fetch takes 3 cycles with one mem_en pulse; invalidate has no observable effect.
